// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: Gray/binary conversion helpers and skid-buffer
// occupancy encoding.
package fifo_pkg;

    localparam logic [1:0] SK_EMPTY = 2'd0;
    localparam logic [1:0] SK_ONE   = 2'd1;
    localparam logic [1:0] SK_TWO   = 2'd2;

    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Prefix-XOR from the MSB down; zero-extended inputs convert correctly.
    function automatic logic [31:0] gray2bin(input logic [31:0] gray);
        logic [31:0] bin;
        bin = gray;
        for (int s = 1; s < 32; s = s * 2) begin
            bin = bin ^ (bin >> s);
        end
        return bin;
    endfunction

endpackage

// File: rtl/g2b.sv
// Gray-to-binary pointer converter, shared by both FIFO clock domains.
module g2b
    import fifo_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    assign bin = W'(gray2bin(32'(gray)));

endmodule

// File: rtl/w_skid_buf.sv
// Two-entry skid buffer between the producer stream and the FIFO write port.
module w_skid_buf
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  wclk,
    input  logic                  wrst,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    input  logic                  full,
    output logic                  wr,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic [1:0]            cnt
);

    logic [1:0]            cnt_r;
    logic [DATA_WIDTH-1:0] e0_r;
    logic [DATA_WIDTH-1:0] e1_r;
    logic                  push_s;
    logic                  pop_s;

    // s_ready depends only on registered occupancy, never on full.
    assign s_ready = (cnt_r != SK_TWO);
    assign wr      = (cnt_r != SK_EMPTY) & ~full;
    assign wdata   = e0_r;
    assign cnt     = cnt_r;
    assign push_s  = s_valid & s_ready;
    assign pop_s   = wr;

    // Occupancy and entry update; e0 is always the head of the queue.
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            cnt_r <= SK_EMPTY;
            e0_r  <= {DATA_WIDTH{1'b0}};
            e1_r  <= {DATA_WIDTH{1'b0}};
        end else begin
            case ({push_s, pop_s})
                2'b10: begin
                    if (cnt_r == SK_EMPTY) begin
                        e0_r <= s_data;
                    end else begin
                        e1_r <= s_data;
                    end
                    cnt_r <= cnt_r + 2'd1;
                end
                2'b01: begin
                    e0_r  <= e1_r;
                    cnt_r <= cnt_r - 2'd1;
                end
                2'b11: begin
                    // Only reachable with one word held: new word becomes head.
                    if (cnt_r == SK_ONE) begin
                        e0_r <= s_data;
                    end else begin
                        e0_r <= e0_r;
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

endmodule

// File: rtl/w_ingress_ctrl.sv
// Write-side ingress of the async FIFO: skid-buffered producer stream, write-domain
// fill level with almost_full, and a saturating full-stall counter.
module w_ingress_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PTR_WIDTH  = 4,
    parameter int AF_THRESH  = 6,
    parameter int STALL_W    = 16
) (
    input  logic                  wclk,
    input  logic                  wrst,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    input  logic                  full,
    input  logic [PTR_WIDTH-1:0]  b_wptr,
    input  logic [PTR_WIDTH-1:0]  g_rptr_sync,
    output logic                  wr,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic [PTR_WIDTH-1:0]  wlevel,
    output logic                  almost_full,
    output logic [STALL_W-1:0]    stall_cnt,
    input  logic                  stall_clr
);

    localparam logic [PTR_WIDTH-1:0] AF_LVL    = PTR_WIDTH'(AF_THRESH);
    localparam logic [STALL_W-1:0]   STALL_MAX = {STALL_W{1'b1}};

    logic [1:0]           cnt_s;
    logic                 blocked_s;
    logic [PTR_WIDTH-1:0] b_rptr_s;
    logic [PTR_WIDTH-1:0] lvl_s;
    logic [PTR_WIDTH-1:0] wlevel_r;
    logic                 almost_full_r;
    logic [STALL_W-1:0]   stall_cnt_r;

    w_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .wclk    (wclk),
        .wrst    (wrst),
        .s_valid (s_valid),
        .s_data  (s_data),
        .s_ready (s_ready),
        .full    (full),
        .wr      (wr),
        .wdata   (wdata),
        .cnt     (cnt_s)
    );

    g2b #(
        .W (PTR_WIDTH)
    ) u_g2b (
        .gray (g_rptr_sync),
        .bin  (b_rptr_s)
    );

    // Modulo subtraction handles differing wrap bits without special casing.
    assign lvl_s     = b_wptr - b_rptr_s;
    assign blocked_s = (cnt_s != SK_EMPTY) & full;

    assign wlevel      = wlevel_r;
    assign almost_full = almost_full_r;
    assign stall_cnt   = stall_cnt_r;

    // Registered level/almost_full and saturating stall counter (clear wins).
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            wlevel_r      <= {PTR_WIDTH{1'b0}};
            almost_full_r <= 1'b0;
            stall_cnt_r   <= {STALL_W{1'b0}};
        end else begin
            wlevel_r      <= lvl_s;
            almost_full_r <= (lvl_s >= AF_LVL);
            if (stall_clr) begin
                stall_cnt_r <= {STALL_W{1'b0}};
            end else if (blocked_s && (stall_cnt_r != STALL_MAX)) begin
                stall_cnt_r <= stall_cnt_r + {{(STALL_W-1){1'b0}}, 1'b1};
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
        end
    end

endmodule
